// File: rtl/bus_data_responder.sv
// Data-bus target: byte-lane RAM, GPIO pair and compare/auto-reload timer.
// Reads are combinational; writes and timer updates commit on clk.
module bus_data_responder #(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_re,
  input  logic [3:0]  bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  localparam logic [2:0] OFF_GOUT = 3'd0;
  localparam logic [2:0] OFF_GIN  = 3'd1;
  localparam logic [2:0] OFF_CTRL = 3'd2;
  localparam logic [2:0] OFF_CNT  = 3'd3;
  localparam logic [2:0] OFF_CMP  = 3'd4;

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0] mem [RAM_WORDS];

  logic [31:0] gpio_out_q, gpio_out_d;
  logic [31:0] gsync1_q, gsync1_d;
  logic [31:0] gsync2_q, gsync2_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        pend_q, pend_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [PW-1:0] pre_q, pre_d;

  logic [31:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          per_hit;
  logic [2:0]    per_off;
  logic          wr_any;
  logic          wr_gout, wr_ctrl, wr_cnt, wr_cmp;
  logic          tick, match, w1c;
  logic [31:0]   cnt_next;
  logic [31:0]   per_rd;

  assign ram_off = bus_addr - RAM_BASE;
  assign ram_idx = ram_off[AW+1:2];
  assign ram_hit = (bus_addr >= RAM_BASE) && ({1'b0, ram_off} < RAM_BYTES);
  assign per_hit = !ram_hit && (bus_addr[31:5] == PERIPH_BASE[31:5]);
  assign per_off = bus_addr[4:2];
  assign wr_any  = |bus_we;

  assign wr_gout = per_hit && wr_any && (per_off == OFF_GOUT);
  assign wr_ctrl = per_hit && wr_any && (per_off == OFF_CTRL);
  assign wr_cnt  = per_hit && wr_any && (per_off == OFF_CNT);
  assign wr_cmp  = per_hit && wr_any && (per_off == OFF_CMP);

  always_comb begin
    tick  = en_q && (pre_q == PRE_MAX);
    match = (count_q == cmp_q);
    w1c   = wr_ctrl && bus_we[0] && bus_wdata[2];
    pre_d = (!en_q || tick) ? '0 : pre_q + 1'b1;

    cnt_next = count_q;
    if (tick) cnt_next = match ? 32'd0 : count_q + 32'd1;
    // Software write wins only on the lanes it touches.
    count_d = wr_cnt ? merge(cnt_next, bus_wdata, bus_we) : cnt_next;
    cmp_d   = wr_cmp ? merge(cmp_q, bus_wdata, bus_we) : cmp_q;
    gpio_out_d = wr_gout ? merge(gpio_out_q, bus_wdata, bus_we)
                         : gpio_out_q;

    en_d     = (wr_ctrl && bus_we[0]) ? bus_wdata[0] : en_q;
    irq_en_d = (wr_ctrl && bus_we[0]) ? bus_wdata[1] : irq_en_q;
    // Hardware set beats a same-cycle W1C.
    pend_d   = (tick && match) || (pend_q && !w1c);

    gsync1_d = gpio_in;
    gsync2_d = gsync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_q <= '0;
      gsync1_q   <= '0;
      gsync2_q   <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      count_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      pre_q      <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gsync1_q   <= gsync1_d;
      gsync2_q   <= gsync2_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      pre_q      <= pre_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_we[i]) mem[ram_idx][8*i +: 8] <= bus_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    per_rd = 32'h0;
    case (per_off)
      OFF_GOUT: per_rd = gpio_out_q;
      OFF_GIN:  per_rd = gsync2_q;
      OFF_CTRL: per_rd = {29'd0, pend_q, irq_en_q, en_q};
      OFF_CNT:  per_rd = count_q;
      OFF_CMP:  per_rd = cmp_q;
      default:  per_rd = 32'h0;
    endcase
  end

  always_comb begin
    bus_rdata = 32'h0;
    if (bus_re) begin
      unique case (1'b1)
        ram_hit: bus_rdata = mem[ram_idx];
        per_hit: bus_rdata = per_rd;
        default: bus_rdata = 32'h0;
      endcase
    end
  end

  assign gpio_out  = gpio_out_q;
  assign timer_irq = pend_q & irq_en_q;

endmodule

// File: tb/tb_bus_data_responder.sv
// Bench for bus_data_responder: vector table, timer/GPIO/reset
// sequences and random RAM/GPIO traffic against a byte-level model.
module tb_bus_data_responder;

  localparam logic [31:0] P = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        timer_irq;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  mb [256];
  logic [31:0] m_gpio;

  bus_data_responder dut (
    .clk(clk), .rst_n(rst_n),
    .bus_re(bus_re), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic re, logic [3:0] we,
      logic [31:0] a, logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.re = re; v.we = we; v.addr = a; v.wdata = d; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] mword(int w);
    return {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
  endfunction

  function automatic logic [31:0] lane_upd(logic [31:0] o,
      logic [31:0] n, logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setb(logic re, logic [3:0] we,
      logic [31:0] a, logic [31:0] d);
    bus_re = re; bus_we = we; bus_addr = a; bus_wdata = d;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] we);
    setb(1'b0, we, a, d);
    step();
    setb(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
    setb(1'b1, 4'h0, a, 32'h0);
    #1;
    check(name, bus_rdata, exp);
    bus_re = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int op, w, a;
    logic re;
    logic [3:0] we;
    logic [31:0] d, e;

    rst_n = 1'b0;
    gpio_in = 32'h0;
    setb(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_irq", {31'd0, timer_irq}, 32'h0);
    rd("rst_cmp", P + 32'h10, 32'hFFFF_FFFF);
    rd("rst_count", P + 32'h0C, 32'h0);
    rd("rst_ctrl", P + 32'h08, 32'h0);
    rd("rst_gpio_in", P + 32'h04, 32'h0);

    vt.push_back(mk(0, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0));
    vt.push_back(mk(0, 4'h1, 32'h10, 32'h0000_00AA, 32'h0));
    vt.push_back(mk(1, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEAA));
    vt.push_back(mk(1, 4'h0, 32'h13, 32'h0, 32'hDEAD_BEAA));
    vt.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h0));
    vt.push_back(mk(0, 4'h6, 32'h10, 32'h0011_2200, 32'h0));
    vt.push_back(mk(1, 4'h0, 32'h10, 32'h0, 32'hDE11_22AA));
    vt.push_back(mk(0, 4'hF, 32'h20, 32'h1111_1111, 32'h0));
    vt.push_back(mk(1, 4'hF, 32'h20, 32'h2222_2222, 32'h1111_1111));
    vt.push_back(mk(1, 4'h0, 32'h20, 32'h0, 32'h2222_2222));
    vt.push_back(mk(1, 4'h0, 32'h4000_0000, 32'h0, 32'h0));
    vt.push_back(mk(0, 4'hF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0));
    vt.push_back(mk(1, 4'h0, 32'h4000_0000, 32'h0, 32'h0));
    vt.push_back(mk(0, 4'hF, 32'h0, 32'h0123_4567, 32'h0));
    vt.push_back(mk(0, 4'hF, 32'h1000, 32'hCAFE_F00D, 32'h0));
    vt.push_back(mk(1, 4'h0, 32'h0, 32'h0, 32'h0123_4567));
    vt.push_back(mk(1, 4'h0, 32'h1000, 32'h0, 32'h0));
    vt.push_back(mk(0, 4'hF, 32'hFFC, 32'h89AB_CDEF, 32'h0));
    vt.push_back(mk(1, 4'h0, 32'hFFC, 32'h0, 32'h89AB_CDEF));
    vt.push_back(mk(0, 4'hF, P + 32'h18, 32'h1234_5678, 32'h0));
    vt.push_back(mk(1, 4'h0, P + 32'h18, 32'h0, 32'h0));
    vt.push_back(mk(1, 4'h0, P + 32'h14, 32'h0, 32'h0));

    foreach (vt[i]) begin
      setb(vt[i].re, vt[i].we, vt[i].addr, vt[i].wdata);
      #1;
      check($sformatf("vec%0d", i), bus_rdata, vt[i].exp);
      step();
      setb(1'b0, 4'h0, 32'h0, 32'h0);
    end

    // Timer with PRESCALE=1: CMP=3, EN|IRQ_EN
    wr(P + 32'h10, 32'd3, 4'hF);
    wr(P + 32'h08, 32'd3, 4'h1);
    rd("tmr_c0", P + 32'h0C, 32'd0);
    step();
    rd("tmr_c1", P + 32'h0C, 32'd1);
    step();
    rd("tmr_c2", P + 32'h0C, 32'd2);
    step();
    rd("tmr_c3", P + 32'h0C, 32'd3);
    check("tmr_irq_pre", {31'd0, timer_irq}, 32'd0);
    step();
    rd("tmr_wrap", P + 32'h0C, 32'd0);
    rd("tmr_pend", P + 32'h08, 32'd7);
    check("tmr_irq_set", {31'd0, timer_irq}, 32'd1);
    wr(P + 32'h08, 32'd7, 4'h1);
    rd("tmr_w1c", P + 32'h08, 32'd3);
    check("tmr_irq_clr", {31'd0, timer_irq}, 32'd0);
    step();
    step();
    rd("coll_c3", P + 32'h0C, 32'd3);
    wr(P + 32'h08, 32'd7, 4'h1);
    rd("coll_pend", P + 32'h08, 32'd7);
    rd("coll_cnt", P + 32'h0C, 32'd0);
    check("coll_irq", {31'd0, timer_irq}, 32'd1);
    wr(P + 32'h08, 32'd4, 4'h1);
    rd("dis_ctrl", P + 32'h08, 32'd0);
    rd("dis_tick", P + 32'h0C, 32'd1);
    step();
    rd("dis_hold", P + 32'h0C, 32'd1);

    wr(P, 32'h5A5A_FFFF, 4'hC);
    check("gpio_out", gpio_out, 32'h5A5A_0000);
    rd("gpio_rd", P, 32'h5A5A_0000);
    gpio_in = 32'h0000_000F;
    step();
    rd("gpio_in_1", P + 32'h04, 32'h0);
    step();
    rd("gpio_in_2", P + 32'h04, 32'h0000_000F);

    m_gpio = 32'h5A5A_0000;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      wr(32'(i * 4), d, 4'hF);
      for (int b = 0; b < 4; b++) mb[i*4+b] = d[8*b +: 8];
    end

    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 3));
      re = 1'($urandom_range(0, 1));
      we = 4'($urandom_range(0, 15));
      d  = $urandom;
      w  = int'($urandom_range(0, 63));
      if (op <= 1) begin
        a = w * 4 + int'($urandom_range(0, 3));
        e = re ? mword(w) : 32'h0;
        setb(re, we, 32'(a), d);
        #1;
        check($sformatf("rnd_ram%0d", it), bus_rdata, e);
        step();
        for (int b = 0; b < 4; b++)
          if (we[b]) mb[w*4+b] = d[8*b +: 8];
      end else if (op == 2) begin
        e = re ? m_gpio : 32'h0;
        setb(re, we, P, d);
        #1;
        check($sformatf("rnd_gpio%0d", it), bus_rdata, e);
        step();
        m_gpio = lane_upd(m_gpio, d, we);
      end else begin
        a = (w[0]) ? int'(32'h4000_0000) + w * 4
                   : int'(P) + 20 + (w % 3) * 4;
        setb(re, we, 32'(a), d);
        #1;
        check($sformatf("rnd_unm%0d", it), bus_rdata, 32'h0);
        step();
      end
      setb(1'b0, 4'h0, 32'h0, 32'h0);
      check($sformatf("rnd_gout%0d", it), gpio_out, m_gpio);
    end

    for (int i = 0; i < 64; i++)
      rd($sformatf("final_w%0d", i), 32'(i * 4), mword(i));

    wr(P + 32'h0C, 32'd7, 4'hF);
    wr(P + 32'h10, 32'd5, 4'hF);
    rd("pre_rst_cnt", P + 32'h0C, 32'd7);
    rst_n = 1'b0;
    setb(1'b0, 4'hF, P, 32'hFFFF_FFFF);
    step();
    rst_n = 1'b1;
    setb(1'b0, 4'h0, 32'h0, 32'h0);
    check("mrst_gpio_out", gpio_out, 32'h0);
    rd("mrst_cnt", P + 32'h0C, 32'h0);
    rd("mrst_cmp", P + 32'h10, 32'hFFFF_FFFF);
    rd("mrst_ctrl", P + 32'h08, 32'h0);
    rd("mrst_gin", P + 32'h04, 32'h0);
    rd("mrst_ram", 32'h10, mword(4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
